adder_arbiter: RTL and testbench



---
 rtl/adder_arbiter.sv | 145 ++++++++++++++
 tb/tb_adder_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one combinational W-bit adder among NREQ requesters, returns {id, sum}.
// Latency: grant at edge N, rsp_valid from cycle N+1; one operation per 2 cycles at best.
// Backpressure: rsp_ready low holds RESP with rsp_* stable and all req_ready low.
// Define ADD_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module adder_arbiter #(
  parameter  int NREQ = 4,
  parameter  int W    = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  input  logic [W:0]           add_sum,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W:0]           rsp_sum,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [IDW-1:0] op_id;

  logic [IDW-1:0] gnt;
  logic [W-1:0]   gnt_a;
  logic [W-1:0]   gnt_b;
  logic           gnt_found;
  logic           slot_free;
  logic           grant_en;

`ifdef ADD_ARB_RR_EN
  logic [IDW-1:0] ptr;
  int             rr_idx;

  // Round-robin pick: first valid requester at or above ptr, wrapping.
  always_comb begin
    gnt       = '0;
    gnt_a     = '0;
    gnt_b     = '0;
    gnt_found = 1'b0;
    rr_idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      rr_idx = int'(ptr) + i;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (!gnt_found && req_valid[rr_idx]) begin
        gnt_found = 1'b1;
        gnt       = IDW'(rr_idx);
        gnt_a     = req_a[rr_idx*W +: W];
        gnt_b     = req_b[rr_idx*W +: W];
      end
    end
  end
`else
  // Fixed-priority pick: the lowest-index valid requester wins.
  always_comb begin
    gnt       = '0;
    gnt_a     = '0;
    gnt_b     = '0;
    gnt_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_found = 1'b1;
        gnt       = IDW'(i);
        gnt_a     = req_a[i*W +: W];
        gnt_b     = req_b[i*W +: W];
      end
    end
  end
`endif

  // The adder slot is free in IDLE, or in RESP on the cycle the result is taken.
  assign slot_free = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign grant_en  = slot_free && gnt_found;
  assign req_ready = grant_en ? (NREQ'(1) << gnt) : '0;

  // Adder inputs come straight from the operand registers, so they move only on a grant.
  assign add_a = op_a;
  assign add_b = op_b;

  // Sequencer FSM with registered rsp_valid/busy; operands latch on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ADD_ARB_RR_EN
      ptr       <= '0;
`endif
    end else begin
      if (grant_en) begin
        op_a  <= gnt_a;
        op_b  <= gnt_b;
        op_id <= gnt;
`ifdef ADD_ARB_RR_EN
        ptr   <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
`endif
      end
      case (state)
        IDLE: begin
          if (grant_en) begin
            state <= EXEC;
            busy  <= 1'b1;
          end
        end
        EXEC: begin
          rsp_sum   <= add_sum;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (grant_en) begin
              state <= EXEC;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: randomized + directed stimulus against a queue-based reference model.
// Grants are predicted from the arbitration rule; responses are popped and compared on output.
// Runs with rsp_ready both held high and randomly throttled.
module tb_adder_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W:0]        add_sum;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W:0]        rsp_sum;
  logic              busy;

  logic [NREQ-1:0]   va;
  logic [W-1:0]      aa[NREQ];
  logic [W-1:0]      bb[NREQ];

  typedef struct {
    int         id;
    logic [W:0] sum;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mptr = 0;
  bit   head_seen = 0;
  int   grant_cnt[NREQ];
  int   handled[NREQ];
  bit   cont_mode = 0;
  int   last_hs = -1;

  always #5 clk = ~clk;

  assign req_valid = va;
  for (genvar k = 0; k < NREQ; k++) begin : g_pack
    assign req_a[k*W +: W] = aa[k];
    assign req_b[k*W +: W] = bb[k];
  end

  // Shared adder sitting outside the block.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration rule applied to the set of valid requesters.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
`ifdef ADD_ARB_RR_EN
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  // Monitor / scoreboard: checks responses against the queue, predicts and records grants.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mptr      = 0;
      head_seen = 0;
      last_hs   = -1;
    end else begin
      int g;
      cyc++;
      chk(busy == (q.size() != 0), "busy", int'(busy), int'(q.size() != 0));
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk(1'b0, "rsp_unexpected", int'(rsp_id), -1);
        end else begin
          if (!head_seen) begin
            chk(cyc == q[0].cyc + 2, "latency", cyc - q[0].cyc, 2);
            head_seen = 1;
          end
          chk(int'(rsp_id) == q[0].id, "rsp_id", int'(rsp_id), q[0].id);
          chk(rsp_sum == q[0].sum, "rsp_sum", int'(rsp_sum), int'(q[0].sum));
          if (rsp_ready) begin
            void'(q.pop_front());
            head_seen = 0;
            if (cont_mode) begin
              if (last_hs >= 0) chk(cyc - last_hs == 2, "throughput", cyc - last_hs, 2);
              last_hs = cyc;
            end
          end
        end
      end
      if (!cont_mode) last_hs = -1;
      if (req_ready != '0) begin
        g = pick(req_valid, mptr);
        chk($onehot(req_ready), "ready_onehot", int'(req_ready), 0);
        chk(q.size() == 0, "grant_while_busy", q.size(), 0);
        if (g < 0) begin
          chk(1'b0, "grant_no_valid", int'(req_ready), 0);
        end else begin
          chk(req_ready == (NREQ'(1) << g), "grant_sel", int'(req_ready), 1 << g);
          q.push_back('{id: g, sum: {1'b0, aa[g]} + {1'b0, bb[g]}, cyc: cyc});
          grant_cnt[g]++;
          mptr = (g + 1) % NREQ;
        end
      end else if (q.size() == 0 && req_valid != '0) begin
        chk(1'b0, "no_grant", 0, int'(req_valid));
      end
    end
  end

  task automatic sync_handled();
    for (int k = 0; k < NREQ; k++) handled[k] = grant_cnt[k];
  endtask

  task automatic drain();
    bit done;
    @(posedge clk); #1;
    va = '0;
    rsp_ready = 1'b1;
    sync_handled();
    done = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    chk(done, "drain_timeout", int'(done), 1);
  endtask

  // Wait (bounded) for requester k to be granted; returns at the granting negedge.
  task automatic wait_grant(input int k, input string nm);
    bit got;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        got = 1;
        break;
      end
    end
    chk(got, nm, int'(got), 1);
  endtask

  task automatic do_one(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] exp);
    @(posedge clk); #1;
    va[k] = 1'b1; aa[k] = a; bb[k] = b;
    wait_grant(k, "do_one_grant");
    @(posedge clk); #1;
    va[k] = 1'b0;
    sync_handled();
    @(negedge clk);
    chk(req_ready == '0, "ready_pulse", int'(req_ready), 0);
    chk(!rsp_valid, "exec_no_valid", int'(rsp_valid), 0);
    @(negedge clk);
    chk(rsp_valid, "do_one_valid", int'(rsp_valid), 1);
    chk(int'(rsp_id) == k, "do_one_id", int'(rsp_id), k);
    chk(rsp_sum == exp, "do_one_sum", int'(rsp_sum), int'(exp));
  endtask

  // mode 1: random traffic + throttled rsp_ready; 2: all requesters continuous; 3: req0 and req3 continuous.
  task automatic run_auto(input int mode, input int ncyc);
    repeat (ncyc) begin
      @(posedge clk); #1;
      rsp_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int k = 0; k < NREQ; k++) begin
        bit want;
        if (grant_cnt[k] != handled[k]) begin
          va[k] = 1'b0;
          handled[k] = grant_cnt[k];
        end
        want = (mode == 1) ? ($urandom_range(0, 2) == 0) :
               (mode == 2) ? 1'b1 : (k == 0 || k == 3);
        if (va[k] && mode == 1 && $urandom_range(0, 15) == 0) begin
          va[k] = 1'b0;
        end else if (!va[k] && want) begin
          va[k] = 1'b1;
          aa[k] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
          bb[k] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
        end
      end
    end
  endtask

  initial begin
    int g0, g3;
    rst_n = 1'b0;
    va = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      aa[k] = '0; bb[k] = '0; grant_cnt[k] = 0; handled[k] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(req_ready == '0, "rst_ready", int'(req_ready), 0);
    chk(!rsp_valid, "rst_valid", int'(rsp_valid), 0);
    chk(!busy, "rst_busy", int'(busy), 0);
    chk(rsp_sum == '0, "rst_sum", int'(rsp_sum), 0);
    chk(rsp_id == '0, "rst_id", int'(rsp_id), 0);
    chk(add_a == '0 && add_b == '0, "rst_add_in", int'({add_a, add_b}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed single operations, including carry-out
    do_one(1, 16'h1234, 16'h0001, 17'h01235);
    do_one(0, 16'hFFFF, 16'h0001, 17'h10000);
    do_one(0, 16'hFFFF, 16'hFFFF, 17'h1FFFE);
    drain();

    // Backpressure: hold RESP for 5 cycles with req2 pending
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    va[0] = 1'b1; aa[0] = 16'h8001; bb[0] = 16'h8002;
    wait_grant(0, "bp_grant");
    @(posedge clk); #1;
    va[0] = 1'b0;
    sync_handled();
    va[2] = 1'b1; aa[2] = 16'h00AA; bb[2] = 16'h0055;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk(rsp_valid, "bp_valid", int'(rsp_valid), 1);
      chk(req_ready == '0, "bp_ready_low", int'(req_ready), 0);
      chk(rsp_sum == 17'h10003, "bp_sum", int'(rsp_sum), 32'h10003);
      chk(rsp_id == 2'd0, "bp_id", int'(rsp_id), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    #1;
    chk(req_ready == 4'b0100, "bp_release_grant", int'(req_ready), 4);
    drain();

    // Continuous traffic from every requester
    cont_mode = 1;
    run_auto(2, 40);
    cont_mode = 0;
    drain();

    // Random traffic with random backpressure and withdrawals
    run_auto(1, 600);
    drain();

    // req0 and req3 always valid
    g0 = grant_cnt[0];
    g3 = grant_cnt[3];
    run_auto(3, 24);
    chk((grant_cnt[0] - g0) + (grant_cnt[3] - g3) >= 10, "two_req_ops",
        (grant_cnt[0] - g0) + (grant_cnt[3] - g3), 10);
`ifdef ADD_ARB_RR_EN
    chk(grant_cnt[3] - g3 >= 4, "rr_req3_served", grant_cnt[3] - g3, 4);
`else
    chk(grant_cnt[3] == g3, "fixed_req3_starved", grant_cnt[3] - g3, 0);
`endif
    drain();

    // Reset asserted during EXEC
    @(posedge clk); #1;
    va[2] = 1'b1; aa[2] = 16'h0F0F; bb[2] = 16'h00F0;
    wait_grant(2, "rstx_grant");
    @(posedge clk); #2;
    rst_n = 1'b0;
    va = '0;
    #1;
    chk(!busy, "rstx_busy", int'(busy), 0);
    chk(!rsp_valid, "rstx_valid", int'(rsp_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(!rsp_valid, "rstx_valid_hold", int'(rsp_valid), 0);
    sync_handled();
    @(posedge clk); #1;
    rst_n = 1'b1;
    va[1] = 1'b1; aa[1] = 16'h0101; bb[1] = 16'h0202;
    va[3] = 1'b1; aa[3] = 16'h0303; bb[3] = 16'h0404;
    @(negedge clk);
    chk(req_ready == 4'b0010, "rstx_first_grant", int'(req_ready), 2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
